// File: rtl/pwm_fade_sequencer.sv
// Per-channel duty-cycle fade sequencer for 8-bit PWM generators.
// Duty values only move on PWM period wraps, so the generators never see a mid-period change.
module pwm_fade_sequencer #(
   parameter int CH_W  = 2,
   parameter int DIV_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [CH_W-1:0]          cmd_ch,
   input  logic [7:0]               cmd_target,
   input  logic [7:0]               cmd_step,
   input  logic [DIV_W-1:0]         tick_div,
   input  logic                     period_wrap,
   input  logic                     hold,
   output logic [(8<<CH_W)-1:0]     duty_out,
   output logic [(1<<CH_W)-1:0]     busy,
   output logic [(1<<CH_W)-1:0]     done
);

   localparam int NUM_CH = 1 << CH_W;

   typedef enum logic {
      IDLE,
      RAMP
   } ch_state_t;

   ch_state_t        state_q  [NUM_CH];
   logic [7:0]       duty_q   [NUM_CH];
   logic [7:0]       target_q [NUM_CH];
   logic [7:0]       step_q   [NUM_CH];
   logic [7:0]       next_duty[NUM_CH];
   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_eff;
   logic             wrap_hit;
   logic             step_en;
   logic             cmd_fire;

   // One ramp step toward target, saturating at the target without overshoot.
   function automatic logic [7:0] ramp_next(input logic [7:0] duty,
                                            input logic [7:0] target,
                                            input logic [7:0] step);
      logic [8:0] sum;
      logic [8:0] diff;
      logic [7:0] result;
      sum    = {1'b0, duty} + {1'b0, step};
      diff   = {1'b0, duty} - {1'b0, step};
      result = target;
      if (step != 8'd0) begin
         if (target > duty) begin
            if (sum < {1'b0, target})
               result = sum[7:0];
         end else begin
            if (!diff[8] && (diff[7:0] > target))
               result = diff[7:0];
         end
      end
      return result;
   endfunction

   assign div_eff  = (tick_div == '0) ? DIV_W'(1) : tick_div;
   assign wrap_hit = (cnt_q >= (div_eff - DIV_W'(1)));
   assign step_en  = period_wrap && !hold && wrap_hit;
   assign cmd_fire = cmd_valid && cmd_ready;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++)
         next_duty[i] = ramp_next(duty_q[i], target_q[i], step_q[i]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_ready <= 1'b0;
         cnt_q     <= '0;
         done      <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= IDLE;
            duty_q[i]   <= 8'd0;
            target_q[i] <= 8'd0;
            step_q[i]   <= 8'd0;
         end
      end else begin
         cmd_ready <= 1'b1;
         if (period_wrap && !hold)
            cnt_q <= wrap_hit ? '0 : cnt_q + DIV_W'(1);
         for (int i = 0; i < NUM_CH; i++) begin
            done[i] <= 1'b0;
            // A command on this channel takes priority over a step landing in the same cycle.
            if (cmd_fire && (cmd_ch == CH_W'(i))) begin
               target_q[i] <= cmd_target;
               step_q[i]   <= cmd_step;
               if (cmd_target == duty_q[i]) begin
                  state_q[i] <= IDLE;
                  done[i]    <= 1'b1;
               end else begin
                  state_q[i] <= RAMP;
               end
            end else if (step_en && (state_q[i] == RAMP)) begin
               duty_q[i] <= next_duty[i];
               if (next_duty[i] == target_q[i]) begin
                  state_q[i] <= IDLE;
                  done[i]    <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign duty_out[8*g +: 8] = duty_q[g];
      assign busy[g]            = (state_q[g] == RAMP);
   end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed testbench for pwm_fade_sequencer: ramps, saturation, prescaler, hold,
// command/step collision and mid-ramp reset, all with hand-computed expectations.
module tb_pwm_fade_sequencer;

   localparam int CH_W  = 2;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [CH_W-1:0]  cmd_ch = '0;
   logic [7:0]       cmd_target = 8'd0;
   logic [7:0]       cmd_step = 8'd0;
   logic [DIV_W-1:0] tick_div = '0;
   logic             period_wrap = 1'b0;
   logic             hold = 1'b0;
   logic [31:0]      duty_out;
   logic [3:0]       busy;
   logic [3:0]       done;

   int checkCount = 0;
   int failCount  = 0;

   pwm_fade_sequencer #(.CH_W(CH_W), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ch     (cmd_ch),
      .cmd_target (cmd_target),
      .cmd_step   (cmd_step),
      .tick_div   (tick_div),
      .period_wrap(period_wrap),
      .hold       (hold),
      .duty_out   (duty_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] dutyOf(input int ch);
      return duty_out[8*ch +: 8];
   endfunction

   task automatic applyStimulus(input int ch, input int target, input int step);
      cmd_valid  = 1'b1;
      cmd_ch     = CH_W'(ch);
      cmd_target = 8'(target);
      cmd_step   = 8'(step);
      tick();
      cmd_valid  = 1'b0;
   endtask

   task automatic doWrap(input int gap);
      repeat (gap) tick();
      period_wrap = 1'b1;
      tick();
      period_wrap = 1'b0;
   endtask

   initial begin
      // Reset state and cmd_ready release timing.
      rst_n = 1'b0;
      repeat (3) tick();
      checkOutput("rst duty_out", duty_out, 32'd0);
      checkOutput("rst busy", busy, 4'd0);
      checkOutput("rst done", done, 4'd0);
      checkOutput("rst cmd_ready", cmd_ready, 1'b0);
      rst_n = 1'b1;
      tick();
      checkOutput("release cmd_ready", cmd_ready, 1'b1);

      // Channel 0 up-ramp 0 -> 100 by 10, one step per wrap.
      tick_div = 16'd1;
      applyStimulus(0, 100, 10);
      checkOutput("t2 busy0 start", busy[0], 1'b1);
      checkOutput("t2 duty0 start", dutyOf(0), 8'd0);
      for (int k = 1; k <= 10; k++) begin
         doWrap(255);
         checkOutput("t2 duty0", dutyOf(0), 32'(10 * k));
         checkOutput("t2 busy0", busy[0], (k < 10) ? 1'b1 : 1'b0);
         checkOutput("t2 done0", done[0], (k == 10) ? 1'b1 : 1'b0);
      end
      tick();
      checkOutput("t2 done0 pulse end", done[0], 1'b0);

      // Channel 1 up with saturation at target, then down with no underflow.
      applyStimulus(1, 25, 10);
      doWrap(4);  checkOutput("t3 up a", dutyOf(1), 8'd10);
      doWrap(4);  checkOutput("t3 up b", dutyOf(1), 8'd20);
      doWrap(4);  checkOutput("t3 up c", dutyOf(1), 8'd25);
      checkOutput("t3 up done", done, 4'b0010);
      applyStimulus(1, 0, 10);
      doWrap(4);  checkOutput("t3 dn a", dutyOf(1), 8'd15);
      doWrap(4);  checkOutput("t3 dn b", dutyOf(1), 8'd5);
      doWrap(4);  checkOutput("t3 dn c", dutyOf(1), 8'd0);
      checkOutput("t3 dn done", done, 4'b0010);
      checkOutput("t3 dn busy", busy, 4'd0);

      // Channel 2 jump (step 0) waits for a wrap; repeat target gives immediate done.
      applyStimulus(2, 200, 0);
      checkOutput("t4 busy2", busy[2], 1'b1);
      repeat (5) tick();
      checkOutput("t4 duty2 before wrap", dutyOf(2), 8'd0);
      period_wrap = 1'b1;
      #0;
      checkOutput("t4 duty2 during wrap", dutyOf(2), 8'd0);
      tick();
      period_wrap = 1'b0;
      checkOutput("t4 duty2 after wrap", dutyOf(2), 8'd200);
      checkOutput("t4 done2", done, 4'b0100);
      applyStimulus(2, 200, 5);
      checkOutput("t4 same-target done2", done, 4'b0100);
      checkOutput("t4 same-target busy2", busy[2], 1'b0);
      tick();
      checkOutput("t4 done2 cleared", done, 4'd0);

      // Prescaler of 3 with hold mid-count; command accepted while held.
      tick_div = 16'd3;
      applyStimulus(0, 40, 20);
      doWrap(3);  checkOutput("t5 wrap1", dutyOf(0), 8'd100);
      doWrap(3);  checkOutput("t5 wrap2", dutyOf(0), 8'd100);
      doWrap(3);  checkOutput("t5 wrap3", dutyOf(0), 8'd80);
      doWrap(3);  checkOutput("t5 wrap4", dutyOf(0), 8'd80);
      hold = 1'b1;
      applyStimulus(1, 30, 30);
      checkOutput("t5 hold cmd busy1", busy[1], 1'b1);
      for (int k = 0; k < 5; k++) doWrap(3);
      checkOutput("t5 hold duty0", dutyOf(0), 8'd80);
      checkOutput("t5 hold duty1", dutyOf(1), 8'd0);
      hold = 1'b0;
      doWrap(3);  checkOutput("t5 resume a", dutyOf(0), 8'd80);
      doWrap(3);  checkOutput("t5 resume b duty0", dutyOf(0), 8'd60);
      checkOutput("t5 resume b duty1", dutyOf(1), 8'd30);
      checkOutput("t5 resume b done", done, 4'b0010);
      checkOutput("t5 resume b busy", busy, 4'b0001);
      doWrap(3);  doWrap(3);  doWrap(3);
      checkOutput("t5 final duty0", dutyOf(0), 8'd40);
      checkOutput("t5 final done", done, 4'b0001);

      // tick_div 0 acts as 1; retarget colliding with a step on channel 3.
      tick_div = 16'd0;
      applyStimulus(3, 200, 20);
      doWrap(3);  checkOutput("t6 up a", dutyOf(3), 8'd20);
      doWrap(3);  checkOutput("t6 up b", dutyOf(3), 8'd40);
      cmd_valid   = 1'b1;
      cmd_ch      = 2'd3;
      cmd_target  = 8'd0;
      cmd_step    = 8'd20;
      period_wrap = 1'b1;
      tick();
      cmd_valid   = 1'b0;
      period_wrap = 1'b0;
      checkOutput("t6 collide duty3", dutyOf(3), 8'd40);
      checkOutput("t6 collide busy3", busy[3], 1'b1);
      doWrap(3);  checkOutput("t6 dn a", dutyOf(3), 8'd20);
      doWrap(3);  checkOutput("t6 dn b", dutyOf(3), 8'd0);
      checkOutput("t6 dn done", done, 4'b1000);

      // Reset in the middle of a ramp.
      applyStimulus(3, 200, 20);
      doWrap(3);  doWrap(3);
      checkOutput("t6 pre-reset duty3", dutyOf(3), 8'd40);
      rst_n = 1'b0;
      tick();
      checkOutput("t6 reset duty_out", duty_out, 32'd0);
      checkOutput("t6 reset busy", busy, 4'd0);
      checkOutput("t6 reset done", done, 4'd0);
      checkOutput("t6 reset cmd_ready", cmd_ready, 1'b0);
      rst_n = 1'b1;
      tick();
      checkOutput("t6 post-reset done", done, 4'd0);
      checkOutput("t6 post-reset cmd_ready", cmd_ready, 1'b1);

      // Saturation at the 0 and 255 rails with a large step.
      applyStimulus(0, 255, 200);
      doWrap(2);  checkOutput("sat up a", dutyOf(0), 8'd200);
      doWrap(2);  checkOutput("sat up b", dutyOf(0), 8'd255);
      checkOutput("sat up done", done, 4'b0001);
      applyStimulus(0, 0, 200);
      doWrap(2);  checkOutput("sat dn a", dutyOf(0), 8'd55);
      doWrap(2);  checkOutput("sat dn b", dutyOf(0), 8'd0);
      checkOutput("sat dn done", done, 4'b0001);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
